// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the two-digit BCD display scanner.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    GAP_T = 2'd0,
    ONES  = 2'd1,
    GAP_O = 2'd2,
    TENS  = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed seven-segment scanner with blanking gaps,
// frame-aligned digit update, leading-zero suppression and display enable.
//
// state | meaning
// GAP_T | dark gap after tens; digit pair transferred on exit
// ONES  | ones digit lit (an=01)
// GAP_O | dark gap after ones
// TENS  | tens digit lit (an=10), optionally blanked when zero
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  input  logic       blank_lz,
  input  logic       en,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] DIG_LD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    sh_t, sh_o;
  logic [3:0]    dp_t, dp_o;
  logic [3:0]    dig_sel;
  logic [6:0]    seg_dec;
  logic [1:0]    an_c;
  logic [6:0]    seg_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GAP_T;
      cnt   <= GAP_LD;
      sh_t  <= 4'd0;
      sh_o  <= 4'd0;
      dp_t  <= 4'd0;
      dp_o  <= 4'd0;
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (load) begin
        sh_t <= tens_in;
        sh_o <= ones_in;
      end
      if (cnt == '0) begin
        case (state)
          GAP_T: begin
            // Transfer reads the shadow before any same-edge load lands.
            state <= ONES;
            cnt   <= DIG_LD;
            dp_t  <= sh_t;
            dp_o  <= sh_o;
            frame <= 1'b1;
          end
          ONES: begin
            state <= GAP_O;
            cnt   <= GAP_LD;
          end
          GAP_O: begin
            state <= TENS;
            cnt   <= DIG_LD;
          end
          TENS: begin
            state <= GAP_T;
            cnt   <= GAP_LD;
          end
        endcase
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign dig_sel = (state == TENS) ? dp_t : dp_o;

  bcd_to_seg u_dec (
    .digit (dig_sel),
    .seg   (seg_dec)
  );

  always_comb begin
    an_c  = 2'b00;
    seg_c = SEG_OFF;
    case (state)
      ONES: begin
        an_c  = 2'b01;
        seg_c = seg_dec;
      end
      TENS: begin
        an_c  = 2'b10;
        seg_c = (blank_lz && dp_t == 4'd0) ? SEG_OFF : seg_dec;
      end
      default: begin
        an_c  = 2'b00;
        seg_c = SEG_OFF;
      end
    endcase
    if (!en) begin
      an_c  = 2'b00;
      seg_c = SEG_OFF;
    end
  end

  assign an  = an_c;
  assign seg = seg_c;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: vector table, hand sequences
// for frame-boundary corners, and random traffic against a phase-based model.
module tb_bcd_display_scanner;

  localparam int D = 4;
  localparam int G = 2;
  localparam int P = 2 * (D + G);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] tens_in = 4'd0;
  logic [3:0] ones_in = 4'd0;
  logic       blank_lz = 1'b0;
  logic       en = 1'b1;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame;

  bcd_display_scanner #(.DIGIT_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .tens_in  (tens_in),
    .ones_in  (ones_in),
    .blank_lz (blank_lz),
    .en       (en),
    .an       (an),
    .seg      (seg),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic       blz;
    logic [6:0] exp_o;
    logic [6:0] exp_t;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         t = 0;
  logic [3:0] m_sh_t, m_sh_o, m_dp_t, m_dp_o;
  logic [6:0] seg_tab [16];
  logic       tbl_on = 1'b0;
  logic [6:0] tbl_o, tbl_t;
  vec_t       vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_sh_t = 4'd0; m_sh_o = 4'd0;
    m_dp_t = 4'd0; m_dp_o = 4'd0;
  endtask

  // One clock cycle: compare at negedge, then advance the model at posedge.
  task automatic step();
    int p;
    logic [1:0] e_an;
    logic [6:0] e_seg;
    @(negedge clk);
    p = t % P;
    e_an = 2'b00;
    e_seg = 7'h00;
    if (p >= G && p < G + D) begin
      e_an = 2'b01;
      e_seg = seg_tab[m_dp_o];
    end else if (p >= 2 * G + D) begin
      e_an = 2'b10;
      e_seg = (blank_lz && m_dp_t == 4'd0) ? 7'h00 : seg_tab[m_dp_t];
    end
    if (!en) begin
      e_an = 2'b00;
      e_seg = 7'h00;
    end
    check("an", int'(an), int'(e_an));
    check("seg", int'(seg), int'(e_seg));
    check("frame", int'(frame), int'(p == G));
    if (tbl_on && en) begin
      if (e_an == 2'b01) check("tbl_ones_seg", int'(seg), int'(tbl_o));
      if (e_an == 2'b10) check("tbl_tens_seg", int'(seg), int'(tbl_t));
    end
    @(posedge clk);
    if (p == G - 1) begin
      m_dp_t = m_sh_t;
      m_dp_o = m_sh_o;
    end
    if (load) begin
      m_sh_t = tens_in;
      m_sh_o = ones_in;
    end
    t++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < P && (t % P) != ph; i++) step();
  endtask

  task automatic do_load(input logic [3:0] tv, input logic [3:0] ov);
    tens_in = tv;
    ones_in = ov;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[0] = '{4'd1,  4'd5,  1'b0, 7'h6D, 7'h06};
    vecs[1] = '{4'd0,  4'd7,  1'b1, 7'h07, 7'h00};
    vecs[2] = '{4'd0,  4'd7,  1'b0, 7'h07, 7'h3F};
    vecs[3] = '{4'd0,  4'd12, 1'b0, 7'h40, 7'h3F};
    vecs[4] = '{4'd15, 4'd3,  1'b1, 7'h4F, 7'h40};
    vecs[5] = '{4'd9,  4'd8,  1'b0, 7'h7F, 7'h6F};
    vecs[6] = '{4'd0,  4'd0,  1'b1, 7'h3F, 7'h00};
    vecs[7] = '{4'd2,  4'd6,  1'b0, 7'h7D, 7'h5B};

    // Power-on reset
    #12;
    check("reset_an", int'(an), 0);
    check("reset_seg", int'(seg), 0);
    check("reset_frame", int'(frame), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    run(2 * P);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      blank_lz = vecs[v].blz;
      do_load(vecs[v].t, vecs[v].o);
      run(P + 2);
      tbl_o = vecs[v].exp_o;
      tbl_t = vecs[v].exp_t;
      tbl_on = 1'b1;
      run(P);
      tbl_on = 1'b0;
    end

    // Deferred update: load mid-ONES keeps the current frame on old digits
    blank_lz = 1'b0;
    do_load(4'd1, 4'd5);
    run(2 * P);
    wait_phase(G + 1);
    tbl_o = 7'h6D; tbl_t = 7'h06; tbl_on = 1'b1;
    do_load(4'd3, 4'd4);
    for (int i = 0; i < P && (t % P) != 0; i++) step();
    tbl_o = 7'h66; tbl_t = 7'h4F;
    run(P);
    tbl_on = 1'b0;

    // Load coinciding with the transfer edge appears one frame later
    wait_phase(G + D);
    do_load(4'd7, 4'd8);
    wait_phase(G - 1);
    do_load(4'd5, 4'd2);
    tbl_o = 7'h7F; tbl_t = 7'h07; tbl_on = 1'b1;
    run(P);
    tbl_o = 7'h5B; tbl_t = 7'h6D;
    run(P);
    tbl_on = 1'b0;

    // Enable masking for a full frame, then resume
    en = 1'b0;
    run(P);
    en = 1'b1;
    run(P);

    // Reset asserted mid-TENS
    wait_phase(2 * G + D + 1);
    check("pre_reset_an", int'(an), 2);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_an", int'(an), 0);
    check("midreset_seg", int'(seg), 0);
    check("midreset_frame", int'(frame), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    run(G);
    check("first_ones_an", int'(an), 1);
    check("first_ones_seg", int'(seg), 'h3F);
    run(P);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 5) == 0);
      tens_in = 4'($urandom_range(0, 15));
      ones_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    load = 1'b0;
    en = 1'b1;
    run(P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed two-digit seven-segment driver that consumes the `tens`/`ones` BCD digit pair from the binary-to-BCD converter. It latches a digit pair on a load strobe and scans it onto a common-segment, two-anode display with a blanking gap between digits. Optional leading-zero suppression and an error glyph are provided. It sits directly downstream of the converter and drives board pins.

## Interface
- `DIGIT_CYCLES`, default 50000: clock cycles each digit is lit; must be ≥1.
- `GAP_CYCLES`, default 500: dark cycles between digits (anti-ghosting); must be ≥1.
- `clk` in 1: the block's only clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load` in 1: single-cycle strobe; capture `tens_in`/`ones_in`.
- `tens_in` in 4: BCD tens digit.
- `ones_in` in 4: BCD ones digit.
- `blank_lz` in 1: when 1, a tens digit of 0 is not lit.
- `en` in 1: display enable; when 0, `an` and `seg` are forced to 0 while the scan keeps running.
- `an` out 2: active-high one-hot digit enable; `an[0]` = ones, `an[1]` = tens.
- `seg` out 7: active-high segments; `seg[0]`=a … `seg[6]`=g.
- `frame` out 1: one-cycle pulse on each GAP_T→ONES transition.

## Operation
- FSM states, in cyclic order: GAP_T → ONES → GAP_O → TENS → GAP_T.
  - ONES and TENS each last exactly `DIGIT_CYCLES` cycles.
  - GAP_O and GAP_T each last exactly `GAP_CYCLES` cycles.
  - A down-counter is reloaded on every state change. Its width is `$clog2` of max(`DIGIT_CYCLES`, `GAP_CYCLES`) + 1.
- Registers:
  - Shadow pair `sh_t`/`sh_o` is written on any edge where `load`=1.
  - Display pair `dp_t`/`dp_o` copies the shadow pair only on the GAP_T→ONES edge, so a frame never mixes old and new digits.
- Outputs are Moore: decoded from the state register and `dp_*` only, never from inputs except `en` and `blank_lz`.
  - GAP_O/GAP_T: `an`=00, `seg`=0.
  - ONES: `an`=01, `seg`=decode(`dp_o`).
  - TENS: `an`=10, `seg`=decode(`dp_t`).
  - In TENS with `blank_lz`=1 and `dp_t`=0: `an`=10, `seg`=0.
- Decode table:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Values 10–15 produce the dash glyph 40 (g only). Leading-zero blanking never applies to the dash.
- `en`=0 masks `an` and `seg` to 0. FSM, counter, shadow and display registers are unaffected.

## Timing
- Reset values:
  - state=GAP_T, counter=`GAP_CYCLES`-1.
  - `sh_*`=`dp_*`=0.
  - `an`=00, `seg`=0, `frame`=0.
- After `rst_n` rises, the first ONES cycle is cycle `GAP_CYCLES` (0-indexed from the first active edge). Frame period = 2·(`DIGIT_CYCLES`+`GAP_CYCLES`).
- Load latency:
  - A load is captured in the shadow pair on the next edge.
  - It becomes visible at the next GAP_T→ONES edge strictly after that capture.
  - If `load` coincides with the GAP_T→ONES edge, the pre-load shadow is transferred. The new value appears one frame later.
- Back-to-back loads: last write before the transfer edge wins. There is no queue and no overflow.
- `frame` is high during the first ONES cycle, i.e. the cycle after the transfer edge.
- Reset mid-scan: all state returns asynchronously to reset values and `an` drops to 00 immediately; the scan restarts from GAP_T.
- Counter reaching 0 at a state boundary: the state change occurs on that edge. No extra cycle is spent.

## Structure
- `bcd_disp_pkg`: state enum (GAP_T, ONES, GAP_O, TENS), the ten segment constants, and `SEG_DASH`=7'h40 and `SEG_OFF`=7'h00.
- Sub-module `bcd_to_seg`: purely combinational 4-bit → 7-segment decoder with dash for >9. It is instantiated once, fed by a mux on `dp_o`/`dp_t` selected by state.
- The top holds the FSM, counter, shadow/display registers and output masking.

## Test plan
- Reset: assert `rst_n`=0 mid-TENS with `DIGIT_CYCLES`=4, `GAP_CYCLES`=2 → `an`=00 and `seg`=00 immediately; after release, ONES is first lit at cycle 2.
- Basic scan: load 1/5, `blank_lz`=0 → per 12-cycle frame, 2 dark cycles, then 4 cycles `an`=01 `seg`=6D, 2 dark, 4 cycles `an`=10 `seg`=06; `frame` pulses once per frame.
- Leading zero: load 0/7 with `blank_lz`=1 → TENS shows `an`=10 `seg`=00. With `blank_lz`=0 → `seg`=3F.
- Invalid digit: load tens=0, ones=12 → ONES `seg`=40. Load tens=0xF with `blank_lz`=1 → TENS `seg`=40.
- Deferred update: load 3/4 mid-ONES → the current frame keeps old digits and the next frame shows 4F/66. Load on the transfer edge → visible one frame later.
- Enable: `en`=0 for one full frame → `an`=00 and `seg`=00 throughout, `frame` still pulses. Re-enabling resumes at the correct phase.
